hazard_unit_p: RTL and testbench
================================

Name: hazard_unit_p

Overview:
Parametrised hazard and stall controller for the in-order 5-stage core (F/D/E/M/W). It generalises the existing hazard block with:
- register-address width as a parameter;
- separate E- and M-stage forwarding sources;
- configurable mul/div latency with an internal busy counter;
- per-port cache-miss wait FSMs;
- pending-flush tracking, so a mispredict that lands during a stall is never lost.

It sits beside the pipeline registers and drives their stall/flush enables and the decode-stage operand muxes.

Parameters:
RAW, 5, register address width
MUL_LAT, 3, mul cycles in E (>=1)
DIV_LAT, 16, div cycles in E (>=1)
CNT_W, 5, busy-counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT)

Ports:
clk  in  1  core clock
rstn  in  1  asynchronous active-low reset
r_src1, r_src2  in  RAW  decode-stage source registers
is_b, is_j  in  1  branch / jump in E stage
pre_taken, real_taken  in  1  predicted / resolved direction of E-stage branch
is_load_e  in  1  E-stage instruction is a load
dst_en_e, r_dst_e  in  1,RAW  E-stage destination valid / address
dst_en_m, r_dst_m  in  1,RAW  M-stage destination valid / address
is_m, is_d  in  1  mul / div issuing into E this cycle
fin  in  1  mul/div unit early finish
f_cmiss, f_arrival  in  1  I-cache miss / refill done
m_cmiss, m_arrival  in  1  D-cache miss / refill done
src1_sel, src2_sel  out  2  00 regfile, 01 forward from E/M latch, 10 forward from M/W latch
fd_st, de_st, em_st, mw_st  out  1  hold pipeline register
fd_flush, de_flush  out  1  insert bubble
md_busy  out  1  mul/div FSM busy

Behaviour:
- Reset (async, rstn=0): all FSMs idle, counter 0, flush_pend 0, all outputs 0. Outputs are Mealy: a function of current state plus current-cycle inputs.
- Forwarding: srcN_sel=01 if dst_en_e && r_dst_e==r_srcN && r_srcN!=0. Else 10 if dst_en_m && r_dst_m==r_srcN && r_srcN!=0. Else 00. E beats M.
- Load-use: is_load_e && (forward match on src1 or src2 from E) gives fd_st=1, de_flush=1 for one cycle. Sel still shows the computed value.
- MD FSM, states MD_IDLE / MD_BUSY:
  - is_m in IDLE: load cnt=MUL_LAT-1. is_d: load cnt=DIV_LAT-1. is_m&&is_d: div wins.
  - If the loaded value is 0, stay IDLE.
  - BUSY: cnt decrements each unstalled cycle. fin or cnt==1 returns to IDLE next edge.
  - While BUSY: md_busy=1, fd_st=de_st=em_st=1.
- IMISS FSM, states I_IDLE / I_WAIT:
  - f_cmiss in IDLE gives fd_st=1 the same cycle and moves to WAIT.
  - WAIT holds fd_st=1 until f_arrival; the cycle with f_arrival deasserts fd_st and returns to IDLE.
  - f_cmiss&&f_arrival in IDLE: no stall.
- DMISS FSM, same shape: m_cmiss/m_arrival, stalling fd, de, em and mw.
- Control flow:
  - mispredict = is_b && (pre_taken!=real_taken); also is_j. Either gives fd_flush=de_flush=1.
  - If em_st=1 that cycle, set flush_pend=1 and suppress the flush; it is issued in the first cycle em_st=0, then cleared.
  - A new mispredict while pend=1 keeps pend=1 and produces one flush only.
- Priority: DMISS > MD busy > IMISS > load-use.
  - A stalled stage never also flushes, except de_flush on load-use, which inserts the bubble.
  - fd_flush overrides fd_st when both are requested by control flow with em_st=0.
- Reset mid-operation clears everything asynchronously; the pending flush is dropped.

Optional Feature:
HAZ_PERF_CNT_EN: adds outputs stall_cyc[31:0] and flush_cnt[15:0].
- stall_cyc counts cycles with fd_st=1; flush_cnt counts cycles with fd_flush=1.
- Both saturate at max and reset to 0.
- Without the macro, neither the ports nor the logic exist.

Test Plan:
- r_src1=3, dst_en_e=1, r_dst_e=3, dst_en_m=1, r_dst_m=3 -> src1_sel=01; r_dst_e=4 -> 01 becomes 10; r_src1=0 -> 00.
- is_load_e=1, r_dst_e=5, r_src2=5 -> one cycle fd_st=1, de_flush=1; next cycle (is_load_e=0) both 0.
- is_d pulse with DIV_LAT=16 -> md_busy high 15 cycles, em_st high 15 cycles; repeat with fin at cycle 4 -> md_busy drops after the fin edge.
- m_cmiss at cycle 10, m_arrival at cycle 20 -> all four stalls high cycles 10-19, low at 20. Mispredict (is_b=1, pre_taken=0, real_taken=1) at cycle 12 -> flushes appear exactly once at cycle 20.
- f_cmiss held with is_j=1 -> fd_flush=1, de_flush=1 while em_st=0; I_WAIT persists until f_arrival.
- rstn low during MD_BUSY with cnt=7 -> md_busy=0 and all stalls 0 immediately; no resumed stall after rstn=1.

Source files
------------

// File: rtl/hazard_unit_p.sv
// Hazard/stall controller for the 5-stage core: forwarding, load-use, mul/div busy,
// I/D cache-miss waits and pending-flush tracking. HAZ_PERF_CNT_EN adds stall/flush counters.
module hazard_unit_p #(
  parameter int unsigned RAW     = 5,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [RAW-1:0] r_src1,
  input  logic [RAW-1:0] r_src2,
  input  logic           is_b,
  input  logic           is_j,
  input  logic           pre_taken,
  input  logic           real_taken,
  input  logic           is_load_e,
  input  logic           dst_en_e,
  input  logic [RAW-1:0] r_dst_e,
  input  logic           dst_en_m,
  input  logic [RAW-1:0] r_dst_m,
  input  logic           is_m,
  input  logic           is_d,
  input  logic           fin,
  input  logic           f_cmiss,
  input  logic           f_arrival,
  input  logic           m_cmiss,
  input  logic           m_arrival,
  output logic [1:0]     src1_sel,
  output logic [1:0]     src2_sel,
  output logic           fd_st,
  output logic           de_st,
  output logic           em_st,
  output logic           mw_st,
  output logic           fd_flush,
  output logic           de_flush,
  output logic           md_busy
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]    stall_cyc,
  output logic [15:0]    flush_cnt
`endif
);

  typedef enum logic { MD_IDLE, MD_BUSY } md_state_e;
  typedef enum logic { I_IDLE, I_WAIT } i_state_e;
  typedef enum logic { D_IDLE, D_WAIT } d_state_e;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  md_state_e        md_q, md_d;
  i_state_e         i_q, i_d;
  d_state_e         dm_q, dm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;

  logic fwd_e1, fwd_e2, fwd_m1, fwd_m2;
  logic load_use, lu_act;
  logic i_stall, d_stall;
  logic mispredict, flush_go;

  always_comb begin
    fwd_e1   = dst_en_e && (r_dst_e == r_src1) && (r_src1 != '0);
    fwd_e2   = dst_en_e && (r_dst_e == r_src2) && (r_src2 != '0);
    fwd_m1   = dst_en_m && (r_dst_m == r_src1) && (r_src1 != '0);
    fwd_m2   = dst_en_m && (r_dst_m == r_src2) && (r_src2 != '0);
    src1_sel = fwd_e1 ? 2'b01 : (fwd_m1 ? 2'b10 : 2'b00);
    src2_sel = fwd_e2 ? 2'b01 : (fwd_m2 ? 2'b10 : 2'b00);
    load_use = is_load_e && (fwd_e1 || fwd_e2);
  end

  // Miss stalls are Mealy: they drop in the very cycle the refill arrives.
  always_comb begin
    i_stall = (i_q == I_WAIT) ? !f_arrival : (f_cmiss && !f_arrival);
    d_stall = (dm_q == D_WAIT) ? !m_arrival : (m_cmiss && !m_arrival);
    i_d     = i_stall ? I_WAIT : I_IDLE;
    dm_d    = d_stall ? D_WAIT : D_IDLE;
  end

  always_comb begin
    md_d  = md_q;
    cnt_d = cnt_q;
    case (md_q)
      MD_IDLE: begin
        if (is_d || is_m) begin
          cnt_d = is_d ? DIV_LOAD : MUL_LOAD;
          if (cnt_d != '0) md_d = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (fin) begin
          md_d  = MD_IDLE;
          cnt_d = '0;
        end else if (!d_stall) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) md_d = MD_IDLE;
        end
      end
      default: begin
        md_d  = MD_IDLE;
        cnt_d = '0;
      end
    endcase
  end

  // A mispredict seen while E/M is held is parked in pend_q and issued once E/M frees.
  always_comb begin
    md_busy    = (md_q == MD_BUSY);
    mw_st      = d_stall;
    em_st      = d_stall || md_busy;
    de_st      = em_st;
    mispredict = (is_b && (pre_taken != real_taken)) || is_j;
    flush_go   = !em_st && (mispredict || pend_q);
    lu_act     = load_use && !em_st;
    fd_st      = em_st || ((i_stall || lu_act) && !flush_go);
    fd_flush   = flush_go;
    de_flush   = flush_go || lu_act;
    pend_d     = em_st ? (pend_q || mispredict) : 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      md_q   <= MD_IDLE;
      i_q    <= I_IDLE;
      dm_q   <= D_IDLE;
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      md_q   <= md_d;
      i_q    <= i_d;
      dm_q   <= dm_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic [15:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (fd_st && (stall_q != '1)) stall_d = stall_q + 32'd1;
    if (fd_flush && (flush_q != '1)) flush_d = flush_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cyc = stall_q;
  assign flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_hazard_unit_p.sv
// Bench for hazard_unit_p: directed plan steps then random traffic against a behavioural model.
module tb_hazard_unit_p;
  localparam int RAW     = 5;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 16;

  logic           clk = 1'b0;
  logic           rstn;
  logic [RAW-1:0] r_src1, r_src2, r_dst_e, r_dst_m;
  logic           is_b, is_j, pre_taken, real_taken, is_load_e;
  logic           dst_en_e, dst_en_m, is_m, is_d, fin;
  logic           f_cmiss, f_arrival, m_cmiss, m_arrival;
  logic [1:0]     src1_sel, src2_sel;
  logic           fd_st, de_st, em_st, mw_st, fd_flush, de_flush, md_busy;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]    stall_cyc;
  logic [15:0]    flush_cnt;
  int             m_stalls, m_flushes;
`endif

  hazard_unit_p #(.RAW(RAW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(5)) dut (
    .clk(clk), .rstn(rstn), .r_src1(r_src1), .r_src2(r_src2),
    .is_b(is_b), .is_j(is_j), .pre_taken(pre_taken), .real_taken(real_taken),
    .is_load_e(is_load_e), .dst_en_e(dst_en_e), .r_dst_e(r_dst_e),
    .dst_en_m(dst_en_m), .r_dst_m(r_dst_m), .is_m(is_m), .is_d(is_d), .fin(fin),
    .f_cmiss(f_cmiss), .f_arrival(f_arrival), .m_cmiss(m_cmiss), .m_arrival(m_arrival),
    .src1_sel(src1_sel), .src2_sel(src2_sel), .fd_st(fd_st), .de_st(de_st),
    .em_st(em_st), .mw_st(mw_st), .fd_flush(fd_flush), .de_flush(de_flush),
    .md_busy(md_busy)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cyc(stall_cyc), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: busy cycles left in the mul/div unit, miss-wait flags, parked flush.
  int md_left;
  bit i_wait, d_wait, pend;
  logic [1:0] e_s1, e_s2;
  bit e_fd_st, e_em, e_mw, e_flush, e_de_flush, e_md, e_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [RAW-1:0] src);
    if (src == 0) return 2'b00;
    if (dst_en_e && r_dst_e == src) return 2'b01;
    if (dst_en_m && r_dst_m == src) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    md_left = 0; i_wait = 0; d_wait = 0; pend = 0;
`ifdef HAZ_PERF_CNT_EN
    m_stalls = 0; m_flushes = 0;
`endif
  endtask

  task automatic model_eval();
    bit im, lu, go;
    e_s1  = fwd(r_src1);
    e_s2  = fwd(r_src2);
    e_md  = md_left > 0;
    e_mw  = d_wait ? !m_arrival : (m_cmiss && !m_arrival);
    im    = i_wait ? !f_arrival : (f_cmiss && !f_arrival);
    e_em  = e_mw || e_md;
    e_mis = (is_b && (pre_taken != real_taken)) || is_j;
    go    = !e_em && (e_mis || pend);
    lu    = is_load_e && (e_s1 == 2'b01 || e_s2 == 2'b01) && !e_em;
    e_fd_st    = e_em || ((im || lu) && !go);
    e_flush    = go;
    e_de_flush = go || lu;
    i_wait = im;
  endtask

  task automatic model_update();
    pend   = e_em ? (pend || e_mis) : 1'b0;
    d_wait = e_mw;
    if (md_left > 0) begin
      if (fin) md_left = 0;
      else if (!e_mw) md_left--;
    end else if (is_d) md_left = DIV_LAT - 1;
    else if (is_m) md_left = MUL_LAT - 1;
`ifdef HAZ_PERF_CNT_EN
    if (e_fd_st) m_stalls++;
    if (e_flush) m_flushes++;
`endif
  endtask

  task automatic tick(input string tag);
    @(negedge clk);
    model_eval();
    chk({tag, ".src1_sel"}, src1_sel, e_s1);
    chk({tag, ".src2_sel"}, src2_sel, e_s2);
    chk({tag, ".fd_st"}, fd_st, e_fd_st);
    chk({tag, ".de_st"}, de_st, e_em);
    chk({tag, ".em_st"}, em_st, e_em);
    chk({tag, ".mw_st"}, mw_st, e_mw);
    chk({tag, ".fd_flush"}, fd_flush, e_flush);
    chk({tag, ".de_flush"}, de_flush, e_de_flush);
    chk({tag, ".md_busy"}, md_busy, e_md);
`ifdef HAZ_PERF_CNT_EN
    chk({tag, ".stall_cyc"}, stall_cyc, m_stalls);
    chk({tag, ".flush_cnt"}, flush_cnt, m_flushes);
`endif
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clr();
    r_src1 = '0; r_src2 = '0; r_dst_e = '0; r_dst_m = '0;
    is_b = 0; is_j = 0; pre_taken = 0; real_taken = 0; is_load_e = 0;
    dst_en_e = 0; dst_en_m = 0; is_m = 0; is_d = 0; fin = 0;
    f_cmiss = 0; f_arrival = 0; m_cmiss = 0; m_arrival = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".stalls"}, {fd_st, de_st, em_st, mw_st}, 4'b0000);
    chk({tag, ".flushes"}, {fd_flush, de_flush}, 2'b00);
    chk({tag, ".md_busy"}, md_busy, 1'b0);
    chk({tag, ".sels"}, {src1_sel, src2_sel}, 4'b0000);
  endtask

  initial begin
    int n_busy, n_em, n_fl;
    clr();
    rstn = 0;
    model_reset();
    #12;
    chk_all_zero("reset");
    rstn = 1;
    @(posedge clk); #1;

    // Forwarding priority and x0 exclusion
    r_src1 = 5'd3; dst_en_e = 1; r_dst_e = 5'd3; dst_en_m = 1; r_dst_m = 5'd3;
    #1 chk("fwd_e_wins", src1_sel, 2'b01);
    tick("fwd_e");
    r_dst_e = 5'd4;
    #1 chk("fwd_m", src1_sel, 2'b10);
    tick("fwd_m");
    r_src1 = '0;
    #1 chk("fwd_x0", src1_sel, 2'b00);
    tick("fwd_x0");
    clr();

    // Load-use bubble
    is_load_e = 1; dst_en_e = 1; r_dst_e = 5'd5; r_src2 = 5'd5;
    #1 chk("lu_bubble", {fd_st, de_flush, src2_sel}, 4'b1101);
    tick("lu");
    is_load_e = 0;
    #1 chk("lu_release", {fd_st, de_flush}, 2'b00);
    tick("lu_after");
    clr();

    // Divide occupies E for DIV_LAT-1 cycles
    is_d = 1; tick("div_issue"); is_d = 0;
    n_busy = 0; n_em = 0;
    repeat (20) begin
      if (md_busy) n_busy++;
      if (em_st) n_em++;
      tick("div_run");
    end
    chk("div_busy_cycles", n_busy, DIV_LAT - 1);
    chk("div_em_cycles", n_em, DIV_LAT - 1);

    // Early finish
    is_d = 1; tick("divf_issue"); is_d = 0;
    repeat (3) tick("divf_run");
    fin = 1; tick("divf_fin"); fin = 0;
    #1 chk("md_after_fin", md_busy, 1'b0);
    tick("divf_idle");

    // D-miss with a mispredict parked during the stall
    m_cmiss = 1;
    #1 chk("dmiss_start", {fd_st, de_st, em_st, mw_st}, 4'b1111);
    tick("dmiss0"); m_cmiss = 0;
    n_fl = 0;
    for (int k = 1; k < 10; k++) begin
      if (k == 2) begin is_b = 1; real_taken = 1; end
      if (fd_flush) n_fl++;
      tick("dmiss_wait");
      is_b = 0; real_taken = 0;
    end
    chk("dmiss_no_early_flush", n_fl, 0);
    m_arrival = 1;
    #1 chk("dmiss_release", {fd_st, mw_st, fd_flush, de_flush}, 4'b0011);
    tick("dmiss_arrive"); m_arrival = 0;
    #1 chk("pend_once", {fd_flush, de_flush}, 2'b00);
    tick("dmiss_after");

    // I-miss with a jump: flush wins over the fetch stall, wait state persists
    f_cmiss = 1; is_j = 1;
    #1 chk("imiss_jump", {fd_flush, de_flush, fd_st}, 3'b110);
    tick("imiss_j0");
    tick("imiss_j1");
    is_j = 0;
    repeat (2) tick("imiss_hold");
    f_cmiss = 0;
    #1 chk("imiss_wait", fd_st, 1'b1);
    repeat (2) tick("imiss_wait");
    f_arrival = 1;
    #1 chk("imiss_arrive", fd_st, 1'b0);
    tick("imiss_arrive"); f_arrival = 0;
    tick("imiss_idle");

    // Asynchronous reset mid-divide drops all state
    is_d = 1; tick("rst_issue"); is_d = 0;
    repeat (8) tick("rst_run");
    chk("rst_pre_busy", md_busy, 1'b1);
    rstn = 0;
    #1 chk_all_zero("rst_async");
    model_reset();
    @(negedge clk); rstn = 1;
    @(posedge clk); #1;
    repeat (3) tick("rst_after");

    // Random traffic
    repeat (600) begin
      r_src1     = RAW'($urandom_range(0, 3));
      r_src2     = RAW'($urandom_range(0, 3));
      r_dst_e    = RAW'($urandom_range(0, 3));
      r_dst_m    = RAW'($urandom_range(0, 3));
      dst_en_e   = $urandom_range(0, 1) == 1;
      dst_en_m   = $urandom_range(0, 1) == 1;
      is_load_e  = $urandom_range(0, 2) == 0;
      is_b       = $urandom_range(0, 5) == 0;
      is_j       = $urandom_range(0, 15) == 0;
      pre_taken  = $urandom_range(0, 1) == 1;
      real_taken = $urandom_range(0, 1) == 1;
      is_m       = $urandom_range(0, 9) == 0;
      is_d       = $urandom_range(0, 19) == 0;
      fin        = $urandom_range(0, 9) == 0;
      f_cmiss    = $urandom_range(0, 9) == 0;
      f_arrival  = $urandom_range(0, 3) == 0;
      m_cmiss    = $urandom_range(0, 14) == 0;
      m_arrival  = $urandom_range(0, 3) == 0;
      tick("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
